// File: rtl/peri_camera_capture.sv
// DVP capture: pairs OV-series bytes into RGB565 pixels, gated by cfg_done plus settling frames.
// Optional macro CAM_GRAY_EN adds a luma stage (wrdata = {Y,Y}, one extra cycle of latency).
module peri_camera_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SKIP_FRAMES = 10
) (
  input  logic        sclk,
  input  logic        s_rst,
  input  logic        cfg_done,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic        original_href,
  output logic        original_wrreq,
  output logic [15:0] original_wrdata,
  output logic        frame_start,
  output logic        line_err
);

  localparam int PW = $clog2(H_ACTIVE + 1);
  localparam int LW = $clog2(V_ACTIVE + 1);
  localparam int SW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
  localparam logic [PW-1:0] H_FULL    = PW'(H_ACTIVE);
  localparam logic [LW:0]   V_FULL    = (LW + 1)'(V_ACTIVE);
  localparam logic [SW-1:0] SKIP_LAST = SW'((SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SKIP, WAIT_VS, CAPTURE} state_t;

  state_t        state;
  logic          vs_r, hr_r, vs_d, hr_d;
  logic [7:0]    d_r;
  logic [SW-1:0] skip_cnt;
  logic          tog;
  logic [7:0]    hi;
  logic [PW-1:0] pix_cnt;
  logic [LW-1:0] line_cnt;
  logic          frame_err;
  logic          s1_href, s1_wrreq;
  logic [15:0]   s1_data;
  logic          frame_start_r, line_err_r;

  logic          vs_rise, hr_rise, hr_fall, capture, eff_tog;
  logic          line_bad, frame_bad;
  logic [LW:0]   lines_done;

  assign vs_rise  = vs_r & ~vs_d;
  assign hr_rise  = hr_r & ~hr_d;
  assign hr_fall  = ~hr_r & hr_d;
  assign capture  = (state == CAPTURE);
  // A new line always begins on the even (high) byte.
  assign eff_tog  = tog & ~hr_rise;
  // Counts the line that may be closing in this very cycle.
  assign lines_done = {1'b0, line_cnt} + {{LW{1'b0}}, hr_fall};
  assign line_bad   = capture & hr_fall & ((pix_cnt != H_FULL) | tog);
  assign frame_bad  = capture & vs_rise & (lines_done != V_FULL);

  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      state         <= IDLE;
      vs_r          <= 1'b0;
      hr_r          <= 1'b0;
      vs_d          <= 1'b0;
      hr_d          <= 1'b0;
      d_r           <= '0;
      skip_cnt      <= '0;
      tog           <= 1'b0;
      hi            <= '0;
      pix_cnt       <= '0;
      line_cnt      <= '0;
      frame_err     <= 1'b0;
      s1_href       <= 1'b0;
      s1_wrreq      <= 1'b0;
      s1_data       <= '0;
      frame_start_r <= 1'b0;
      line_err_r    <= 1'b0;
    end else begin
      vs_r          <= cam_vsync;
      hr_r          <= cam_href;
      d_r           <= cam_data;
      vs_d          <= vs_r;
      hr_d          <= hr_r;
      frame_start_r <= 1'b0;
      s1_wrreq      <= 1'b0;
      if (!cfg_done) begin
        state      <= IDLE;
        s1_href    <= 1'b0;
        tog        <= 1'b0;
        pix_cnt    <= '0;
        line_cnt   <= '0;
        skip_cnt   <= '0;
        frame_err  <= 1'b0;
        line_err_r <= 1'b0;
      end else begin
        s1_href <= capture & hr_r;
        case (state)
          IDLE: begin
            skip_cnt <= '0;
            state    <= (SKIP_FRAMES == 0) ? WAIT_VS : SKIP;
          end
          SKIP: begin
            if (vs_rise) begin
              if (skip_cnt == SKIP_LAST) state <= WAIT_VS;
              else skip_cnt <= skip_cnt + 1'b1;
            end
          end
          WAIT_VS: begin
            if (vs_rise) begin
              state         <= CAPTURE;
              frame_start_r <= 1'b1;
              line_cnt      <= '0;
              frame_err     <= 1'b0;
              line_err_r    <= 1'b0;
            end
          end
          CAPTURE: begin
            // Error set wins over the frame-boundary clear.
            if (vs_rise) begin
              frame_start_r <= 1'b1;
              line_cnt      <= '0;
              frame_err     <= 1'b0;
              line_err_r    <= frame_err | line_bad | frame_bad;
            end else begin
              if (hr_fall && line_cnt != '1) line_cnt <= line_cnt + 1'b1;
              if (line_bad) begin
                frame_err  <= 1'b1;
                line_err_r <= 1'b1;
              end
            end
            if (hr_r) begin
              if (!eff_tog) begin
                hi  <= d_r;
                tog <= 1'b1;
                if (hr_rise) pix_cnt <= '0;
              end else begin
                tog      <= 1'b0;
                s1_wrreq <= 1'b1;
                s1_data  <= {hi, d_r};
                if (pix_cnt != '1) pix_cnt <= pix_cnt + 1'b1;
              end
            end else if (hr_fall) begin
              tog <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef CAM_GRAY_EN
  logic [7:0]  r8, g8, b8, y;
  logic [16:0] y_sum;
  logic        s2_href, s2_wrreq;
  logic [15:0] s2_data;

  assign r8    = {s1_data[15:11], s1_data[15:13]};
  assign g8    = {s1_data[10:5],  s1_data[10:9]};
  assign b8    = {s1_data[4:0],   s1_data[4:2]};
  assign y_sum = 17'(r8) * 17'd77 + 17'(g8) * 17'd150 + 17'(b8) * 17'd29;
  assign y     = y_sum[16] ? 8'hFF : y_sum[15:8];

  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      s2_href  <= 1'b0;
      s2_wrreq <= 1'b0;
      s2_data  <= '0;
    end else begin
      s2_href  <= s1_href & cfg_done;
      s2_wrreq <= s1_wrreq & cfg_done;
      if (s1_wrreq && cfg_done) s2_data <= {y, y};
    end
  end

  assign original_href   = s2_href;
  assign original_wrreq  = s2_wrreq;
  assign original_wrdata = s2_data;
`else
  assign original_href   = s1_href;
  assign original_wrreq  = s1_wrreq;
  assign original_wrdata = s1_data;
`endif

  assign frame_start = frame_start_r;
  assign line_err    = line_err_r;

endmodule
